// File: rtl/rob_recovery_ctrl.sv
// Branch-mispredict recovery sequencer: flush, youngest-first ROB walk
// releasing destinations and restoring the RAT, then fetch redirect.
module rob_recovery_ctrl #(
    parameter int ADDR_WIDTH    = 32,
    parameter int NUM_ROB_ENTRY = 16,
    parameter int ROB_WIDTH     = 4,
    parameter int PHY_WIDTH     = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mispredict_valid,
    input  logic [ADDR_WIDTH-1:0] mispredict_target,
    input  logic [ROB_WIDTH-1:0]  rob_head,
    input  logic [ROB_WIDTH:0]    rob_count,
    output logic [ROB_WIDTH-1:0]  walk_idx,
    input  logic [4:0]            walk_rd_arch,
    input  logic [PHY_WIDTH-1:0]  walk_rd_phy_old,
    input  logic [PHY_WIDTH-1:0]  walk_rd_phy_new,
    input  logic                  walk_has_rd,
    output logic                  release_valid,
    input  logic                  release_ready,
    output logic [PHY_WIDTH-1:0]  release_pr,
    output logic [4:0]            restore_arch,
    output logic [PHY_WIDTH-1:0]  restore_pr,
    output logic                  pipe_flush,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  redirect_ready,
    output logic                  rob_clear,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, FLUSH, WALK, REDIRECT} state_t;

    localparam logic [ROB_WIDTH-1:0] ONE  = {{(ROB_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ROB_WIDTH:0]   ONEC = {{ROB_WIDTH{1'b0}}, 1'b1};

    state_t                 state;
    logic [ROB_WIDTH-1:0]   ptr;
    logic [ROB_WIDTH-1:0]   remaining;
    logic [ROB_WIDTH:0]     cnt_m1;
    logic                   need;
    logic                   adv;

    assign cnt_m1 = rob_count - ONEC;
    assign need   = (state == WALK) && walk_has_rd && (walk_rd_arch != 5'd0);
    assign adv    = !need || release_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            remaining   <= '0;
            redirect_pc <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mispredict_valid) begin
                        redirect_pc <= mispredict_target;
                        ptr         <= rob_head + cnt_m1[ROB_WIDTH-1:0];
                        // an empty ROB is illegal; degrade to a bare redirect
                        remaining   <= (rob_count == '0) ? '0
                                                         : cnt_m1[ROB_WIDTH-1:0];
                        state       <= FLUSH;
                    end
                end
                FLUSH: state <= (remaining != '0) ? WALK : REDIRECT;
                WALK: begin
                    if (adv) begin
                        ptr       <= ptr - ONE;
                        remaining <= remaining - ONE;
                        if (remaining == ONE) state <= REDIRECT;
                    end
                end
                REDIRECT: if (redirect_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign walk_idx       = (state == WALK) ? ptr : '0;
    assign release_valid  = need;
    assign release_pr     = need ? walk_rd_phy_new : '0;
    assign restore_arch   = need ? walk_rd_arch    : '0;
    assign restore_pr     = need ? walk_rd_phy_old : '0;
    assign pipe_flush     = (state == FLUSH);
    assign redirect_valid = (state == REDIRECT);
    assign rob_clear      = (state == REDIRECT) && redirect_ready;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Bench for rob_recovery_ctrl: queue-based recovery model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_rob_recovery_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mispredict_valid;
    logic [31:0] mispredict_target;
    logic [3:0]  rob_head;
    logic [4:0]  rob_count;
    logic [3:0]  walk_idx;
    logic [4:0]  walk_rd_arch;
    logic [5:0]  walk_rd_phy_old;
    logic [5:0]  walk_rd_phy_new;
    logic        walk_has_rd;
    logic        release_valid;
    logic        release_ready;
    logic [5:0]  release_pr;
    logic [4:0]  restore_arch;
    logic [5:0]  restore_pr;
    logic        pipe_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        rob_clear;
    logic        busy;

    logic [4:0] ent_arch [16];
    logic [5:0] ent_old  [16];
    logic [5:0] ent_new  [16];
    logic       ent_has  [16];

    assign walk_rd_arch    = ent_arch[walk_idx];
    assign walk_rd_phy_old = ent_old[walk_idx];
    assign walk_rd_phy_new = ent_new[walk_idx];
    assign walk_has_rd     = ent_has[walk_idx];

    rob_recovery_ctrl dut (
        .clk(clk), .rst(rst),
        .mispredict_valid(mispredict_valid),
        .mispredict_target(mispredict_target),
        .rob_head(rob_head), .rob_count(rob_count),
        .walk_idx(walk_idx), .walk_rd_arch(walk_rd_arch),
        .walk_rd_phy_old(walk_rd_phy_old),
        .walk_rd_phy_new(walk_rd_phy_new),
        .walk_has_rd(walk_has_rd),
        .release_valid(release_valid), .release_ready(release_ready),
        .release_pr(release_pr), .restore_arch(restore_arch),
        .restore_pr(restore_pr), .pipe_flush(pipe_flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .rob_clear(rob_clear),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit checking = 0;

    // model: phase 0 idle, 1 flush, 2 walking, 3 redirecting
    int          phase = 0;
    int          walkq [$];
    logic [31:0] pc_m = '0;

    logic [3:0]  obs_idx;
    logic [5:0]  obs_rpr;
    logic [31:0] obs_pc;
    logic        obs_relv, obs_flush, obs_rv, obs_clear, obs_busy;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    task automatic cyc();
        int  idx;
        bit  need;
        #1;
        idx  = (phase == 2) ? walkq[0] : 0;
        need = (phase == 2) && ent_has[idx] && (ent_arch[idx] != 5'd0);
        if (checking) begin
            chk("walk_idx", walk_idx, 64'(idx));
            chk("release_valid", release_valid, 64'(need));
            chk("release_pr", release_pr, need ? 64'(ent_new[idx]) : 0);
            chk("restore_arch", restore_arch, need ? 64'(ent_arch[idx]) : 0);
            chk("restore_pr", restore_pr, need ? 64'(ent_old[idx]) : 0);
            chk("pipe_flush", pipe_flush, 64'(phase == 1));
            chk("redirect_valid", redirect_valid, 64'(phase == 3));
            chk("redirect_pc", redirect_pc, 64'(pc_m));
            chk("rob_clear", rob_clear, 64'(phase == 3 && redirect_ready));
            chk("busy", busy, 64'(phase != 0));
        end
        obs_idx = walk_idx; obs_rpr = release_pr; obs_pc = redirect_pc;
        obs_relv = release_valid; obs_flush = pipe_flush;
        obs_rv = redirect_valid; obs_clear = rob_clear; obs_busy = busy;
        @(posedge clk);
        if (rst) begin
            phase = 0;
            walkq.delete();
            pc_m = '0;
        end else begin
            case (phase)
                0: if (mispredict_valid) begin
                    int n;
                    pc_m = mispredict_target;
                    walkq.delete();
                    n = (rob_count == 0) ? 0 : int'(rob_count) - 1;
                    for (int k = 0; k < n; k++)
                        walkq.push_back((int'(rob_head) + int'(rob_count) - 1 - k) & 15);
                    phase = 1;
                end
                1: phase = (walkq.size() == 0) ? 3 : 2;
                2: if (!need || release_ready) begin
                    void'(walkq.pop_front());
                    if (walkq.size() == 0) phase = 3;
                end
                3: if (redirect_ready) phase = 0;
                default: phase = 0;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic go(int head, int count, logic [31:0] tgt);
        mispredict_valid = 1; rob_head = 4'(head);
        rob_count = 5'(count); mispredict_target = tgt;
        cyc();
        mispredict_valid = 0;
        cyc();
    endtask

    initial begin
        rst = 1; mispredict_valid = 0; mispredict_target = '0;
        rob_head = '0; rob_count = '0;
        release_ready = 1; redirect_ready = 1;
        for (int i = 0; i < 16; i++) begin
            ent_arch[i] = 5'(i + 1); ent_old[i] = 6'(20 + i);
            ent_new[i] = 6'(40 + i); ent_has[i] = 1;
        end
        cyc();
        checking = 1;
        cyc();
        chk("rst_busy", obs_busy, 0);
        chk("rst_pc", obs_pc, 0);
        chk("rst_idx", obs_idx, 0);
        rst = 0;

        // single-entry ROB: bare redirect
        go(3, 1, 32'h100);
        chk("t1_flush", obs_flush, 1);
        cyc();
        chk("t1_rv", obs_rv, 1);
        chk("t1_pc", obs_pc, 32'h100);
        chk("t1_clear", obs_clear, 1);
        chk("t1_relv", obs_relv, 0);
        cyc();
        chk("t1_idle", obs_busy, 0);

        // plain walk, with an ignored mispredict mid-walk
        go(2, 4, 32'h200);
        cyc(); chk("t2_idx5", obs_idx, 5); chk("t2_pr45", obs_rpr, 45);
        mispredict_valid = 1; mispredict_target = 32'h999;
        cyc(); chk("t2_idx4", obs_idx, 4); chk("t2_pr44", obs_rpr, 44);
        mispredict_valid = 0;
        cyc(); chk("t2_idx3", obs_idx, 3); chk("t2_pr43", obs_rpr, 43);
        cyc(); chk("t2_rv", obs_rv, 1); chk("t2_pc", obs_pc, 32'h200);

        // wrap
        go(14, 4, 32'h300);
        cyc(); chk("t3_idx1", obs_idx, 1);
        cyc(); chk("t3_idx0", obs_idx, 0);
        cyc(); chk("t3_idx15", obs_idx, 15);
        cyc(); chk("t3_rv", obs_rv, 1);

        // release backpressure
        go(2, 4, 32'h400);
        release_ready = 0;
        cyc(); chk("t4_s0", obs_idx, 5); chk("t4_v0", obs_relv, 1);
        cyc(); chk("t4_s1", obs_idx, 5); chk("t4_p1", obs_rpr, 45);
        release_ready = 1;
        cyc(); chk("t4_s2", obs_idx, 5);
        cyc(); chk("t4_i4", obs_idx, 4);
        cyc(); chk("t4_i3", obs_idx, 3);
        cyc(); chk("t4_rv", obs_rv, 1);

        // no-destination entries never stall; redirect backpressure
        ent_arch[5] = 0; ent_has[4] = 0;
        release_ready = 0;
        go(2, 4, 32'h500);
        cyc(); chk("t5_nr5", obs_relv, 0); chk("t5_i5", obs_idx, 5);
        cyc(); chk("t5_nr4", obs_relv, 0); chk("t5_i4", obs_idx, 4);
        release_ready = 1;
        redirect_ready = 0;
        cyc(); chk("t5_i3", obs_idx, 3);
        for (int i = 0; i < 3; i++) begin
            cyc(); chk("t5_hold", obs_rv, 1); chk("t5_noclr", obs_clear, 0);
        end
        redirect_ready = 1;
        cyc(); chk("t5_clr", obs_clear, 1);
        cyc(); chk("t5_idle", obs_busy, 0);
        ent_arch[5] = 6; ent_has[4] = 1;

        // reset mid-walk, then a clean recovery
        go(0, 8, 32'h600);
        cyc(); cyc();
        rst = 1; cyc();
        rst = 0; cyc();
        chk("t6_busy", obs_busy, 0);
        chk("t6_pc", obs_pc, 0);
        chk("t6_idx", obs_idx, 0);
        go(1, 3, 32'h700);
        begin
            bit seen = 0;
            for (int i = 0; i < 30 && !seen; i++) begin
                cyc();
                if (obs_rv) seen = 1;
            end
            chk("t6_redirect_seen", seen, 1);
            chk("t6_pc2", obs_pc, 32'h700);
        end
        cyc();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int e = $urandom_range(0, 15);
            ent_arch[e] = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
            ent_old[e]  = 6'($urandom);
            ent_new[e]  = 6'($urandom);
            ent_has[e]  = ($urandom % 5 != 0);
            mispredict_valid  = ($urandom % 6 == 0);
            mispredict_target = $urandom;
            rob_head          = 4'($urandom);
            rob_count         = 5'($urandom_range(0, 16));
            release_ready     = ($urandom % 4 != 0);
            redirect_ready    = ($urandom % 3 != 0);
            rst               = ($urandom % 250 == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
